mul_seq: RTL and testbench
==========================

# mul_seq

Iterative 64-bit multiply sequencer for the EX stage. It runs shift-and-add multiplication on the shared EX-stage ALU instead of a dedicated multiplier. While it holds the ALU it stalls the pipeline, then returns the low 64 bits of the product with a one-cycle `done` pulse. The EX-stage operand/ALUOp mux selects the sequencer's ALU drive whenever `alu_own` is high.

## Interface
- `WIDTH`, 64: operand, product and ALU width.
- `CNT_W`, 7: iteration counter width; must satisfy 2^CNT_W > WIDTH.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a multiply; sampled only in IDLE.
- `op_a` input WIDTH: multiplicand; sampled with `start`.
- `op_b` input WIDTH: multiplier; sampled with `start`.
- `flush` input 1: synchronous abort from a pipeline flush.
- `alu_result` input WIDTH: Result output of the shared ALU.
- `alu_a` output WIDTH: ALU operand A.
- `alu_b` output WIDTH: ALU operand B.
- `alu_op` output 4: ALUOp code driven to the ALU.
- `alu_own` output 1: the sequencer owns the ALU this cycle.
- `stall` output 1: hold IF/ID/EX pipeline registers.
- `busy` output 1: state is RUN.
- `done` output 1: one-cycle pulse; `product` is valid.
- `product` output WIDTH: low WIDTH bits of op_a*op_b; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - `acc` (WIDTH): running sum.
  - `mcand` (WIDTH): shifted multiplicand.
  - `mplier` (WIDTH): remaining multiplier bits.
  - `cnt` (CNT_W): iteration count.
- IDLE with `start`=1:
  - Load `acc`=0, `mcand`=op_a, `mplier`=op_b, `cnt`=0.
  - Next state is RUN if op_b≠0; otherwise DONE with `product`=0.
- IDLE with `start`=0: stay in IDLE.
- Each RUN cycle:
  - Drive `alu_a`=`acc`, `alu_b`=`mcand`, `alu_op`=4'b0010 (ADD).
  - If `mplier[0]`=1, `acc` ← `alu_result`; otherwise `acc` is unchanged.
  - `mcand` ← `mcand`<<1, truncated to WIDTH; bits shifted out are discarded.
  - `mplier` ← `mplier`>>1; `cnt` ← `cnt`+1.
  - If `mplier`>>1 == 0, go to DONE and load `product` with the final accumulator (the updated value).
  - Addition wraps modulo 2^WIDTH; there is no overflow flag.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` outside IDLE is ignored. The pipeline never issues one, because `stall` is high.
- Outside RUN: `alu_a`=0, `alu_b`=0, `alu_op`=4'b0000, `alu_own`=0.
- `flush`=1 in any state:
  - Next state is IDLE and no `done` is produced.
  - `product` keeps its previous value; `acc`, `mplier` and `cnt` clear.
  - Flush has priority over `start` and over the RUN→DONE transition.
- Reset values: state IDLE; `acc`, `mcand`, `mplier`, `cnt`, `product` all 0; `busy`, `done`, `stall`, `alu_own` all 0; `alu_a`, `alu_b` 0; `alu_op` 4'b0000.
- Reset is asynchronous: assertion mid-RUN aborts immediately and forces all reset values.

## Timing
- `stall` is combinational: (IDLE & `start` & !`flush`) | RUN. It is low in DONE, so the pipeline advances on the DONE cycle and captures `product`.
- `busy`, `alu_own`, the ALU drive outputs and `done` are decoded from registered state; they are glitch-free after the clock edge.
- Latency is counted from the IDLE cycle in which `start` is sampled to the cycle in which `done`=1:
  - op_b=0: 1 cycle.
  - Otherwise: msb_index(op_b)+2 cycles.
  - Worst case, op_b[63]=1: 65 cycles.
- The ALU path is combinational within a RUN cycle; `alu_result` must settle within one clock.
- Back-to-back operation: a new `start` is accepted in the IDLE cycle that immediately follows DONE.

## Test plan
- op_a=3, op_b=5, using a real ALU instance → `busy` high for 3 cycles; `done` 4 cycles after start; `product`=15; `alu_op`=4'b0010 only while `busy`.
- op_a=0x1234, op_b=0 → `done` 1 cycle after start; `product`=0; `alu_own` never asserts.
- op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=2 → `product`=64'hFFFF_FFFF_FFFF_FFFE (wrap); latency 3.
- op_a=1, op_b=64'h8000_0000_0000_0000 → `product`=64'h8000_0000_0000_0000; latency 65; `stall` high for all 64 RUN cycles.
- Start 7×9 and pulse `flush` on the 2nd RUN cycle → IDLE next cycle; no `done`; `product` keeps its prior value. A new start of 6×7 then gives 42.
- Deassert `rst_n` mid-RUN → all outputs at reset values within the same cycle. Additionally, `start` pulsed during RUN is ignored and does not change the final result.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-and-add 64-bit multiplier that borrows the shared
// EX-stage ALU. While it owns the ALU it stalls the pipeline. When it finishes
// it pulses done for one cycle and presents the low WIDTH bits of the product.
module mul_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_own,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b0000;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // Next-iteration values. The ALU adds acc+mcand every RUN cycle; the sum
  // is only kept when the current multiplier bit is set.
  logic [WIDTH-1:0] mplier_shr;
  logic [WIDTH-1:0] acc_nxt;

  assign mplier_shr = mplier >> 1;
  assign acc_nxt    = mplier[0] ? alu_result : acc;

  // Sequencer state and datapath registers; flush wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (flush) begin
      // Abort: drop the in-flight operation, keep the last good product.
      state  <= S_IDLE;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
            if (op_b == '0) begin
              // Zero multiplier: skip RUN entirely.
              state   <= S_DONE;
              product <= '0;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          cnt    <= cnt + CNT_W'(1);
          // Stop as soon as no multiplier bits remain, not after WIDTH steps.
          if (mplier_shr == '0) begin
            state   <= S_DONE;
            product <= acc_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and ALU drive decoded from the registered state only.
  always_comb begin
    busy    = (state == S_RUN);
    done    = (state == S_DONE);
    alu_own = busy;
    alu_a   = busy ? acc   : '0;
    alu_b   = busy ? mcand : '0;
    alu_op  = busy ? ALU_ADD : ALU_NOP;
  end

  // Stall must rise in the same cycle the request is accepted, so it looks
  // at start directly; it drops in DONE to let the pipeline take product.
  always_comb begin
    stall = ((state == S_IDLE) && start && !flush) || (state == S_RUN);
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with a small behavioural ALU and a scoreboard
// of expected products.
module tb_mul_seq;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic [W-1:0] alu_result;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic         alu_own;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] sb_q[$];

  mul_seq #(.WIDTH(W), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .flush(flush), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_own(alu_own), .stall(stall), .busy(busy),
    .done(done), .product(product)
  );

  // Stand-in for the shared EX ALU.
  always_comb begin
    case (alu_op)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int exp_latency(input logic [W-1:0] b);
    int m = -1;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return (m < 0) ? 1 : m + 2;
  endfunction

  // Every cycle: ALU drive only while busy, stall always high in RUN.
  always @(negedge clk) begin
    logic ok;
    ok = busy ? (alu_own === 1'b1 && alu_op === 4'b0010 && stall === 1'b1)
              : (alu_own === 1'b0 && alu_op === 4'b0000 && alu_a === '0 && alu_b === '0);
    check("alu_drive", {63'd0, ok}, 64'd1);
  end

  // Issue one multiply, wait for done (bounded), compare with scoreboard.
  // If mid_start is set, a bogus start is pulsed during RUN.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mid_start);
    int lat, nbusy, nrun_stall, want_lat;
    logic [W-1:0] exp;
    want_lat = exp_latency(b);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    sb_q.push_back(a * b);
    #1 check({tag, "_stall_at_start"}, {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0; op_a = '0; op_b = '0;
    lat = 0; nbusy = 0; nrun_stall = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (busy && stall) nrun_stall++;
      if (mid_start && lat == 2) begin start = 1'b1; op_a = 64'd99; op_b = 64'd99; end
      if (mid_start && lat == 3) begin start = 1'b0; op_a = '0; op_b = '0; end
      if (done) break;
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      exp = sb_q.pop_front();
      check({tag, "_product"}, product, exp);
      check({tag, "_latency"}, 64'(lat), 64'(want_lat));
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'(want_lat - 1));
      check({tag, "_stall_in_run"}, 64'(nrun_stall), 64'(want_lat - 1));
      check({tag, "_stall_low_done"}, {63'd0, stall}, 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] prior;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_product", product, 64'd0);
    rst_n = 1'b1;

    run_mul("mul_3x5", 64'd3, 64'd5, 1'b0);
    run_mul("mul_zero_b", 64'h1234, 64'd0, 1'b0);
    run_mul("mul_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    run_mul("mul_msb", 64'd1, 64'h8000_0000_0000_0000, 1'b0);
    run_mul("mul_mid_start", 64'd13, 64'hF0, 1'b1);
    for (int i = 0; i < 4; i++)
      run_mul("mul_rand", {$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 60), 1'b0);

    // Flush on the second RUN cycle of 7x9.
    prior = product;
    @(negedge clk);
    start = 1'b1; op_a = 64'd7; op_b = 64'd9;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_stall_in_run", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {63'd0, busy}, 64'd0);
    check("flush_product_kept", product, prior);
    begin
      int nd = 0;
      repeat (6) begin @(negedge clk); if (done) nd++; end
      check("flush_no_done", 64'(nd), 64'd0);
    end
    run_mul("mul_6x7", 64'd6, 64'd7, 1'b0);
    check("mul_6x7_is_42", product, 64'd42);

    // Asynchronous reset in the middle of a long RUN.
    @(negedge clk);
    start = 1'b1; op_a = 64'd5; op_b = 64'h8000_0000_0000_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_own", {63'd0, alu_own}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    check("arst_alu_a", alu_a, 64'd0);
    check("arst_alu_b", alu_b, 64'd0);
    check("arst_alu_op", {60'd0, alu_op}, 64'd0);
    check("arst_product", product, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("mul_after_rst", 64'd11, 64'd12, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
